// File: rtl/instr_mem_loader.sv
// Byte-stream program loader: assembles a framed, checksummed image into the instruction
// memory write port and holds the CPU in reset until the image is verified.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH  = 5,
  parameter int unsigned MAX_WORDS   = 32,
  parameter logic [7:0]  HEADER_BYTE = 8'hA5
) (
  input  logic                  MAX10_CLK1_50,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_data,
  output logic                  mem_wren,
  output logic                  cpu_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count
);

  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [2:0] {
    StIdle, StHdr, StLen, StData, StWrite, StCsum, StDone, StErr
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         len_q;
  logic [CW-1:0]         word_idx_q;
  logic [1:0]            byte_idx_q;
  logic [23:0]           word_buf_q;
  logic [7:0]            csum_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [31:0]           mem_data_q;
  logic [CW-1:0]         word_count_q;

  logic accept, arm, len_ok, last_word;

  assign accept    = rx_valid & rx_ready;
  assign arm       = start & (state_q == StIdle || state_q == StDone || state_q == StErr);
  assign len_ok    = (rx_data != 8'd0) && (32'(rx_data) <= MAX_WORDS);
  assign last_word = (word_idx_q == len_q - CW'(1));

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StErr: if (start) state_d = StHdr;
      StHdr:   if (accept) state_d = (rx_data == HEADER_BYTE) ? StLen : StErr;
      StLen:   if (accept) state_d = len_ok ? StData : StErr;
      StData:  if (accept && byte_idx_q == 2'd3) state_d = StWrite;
      StWrite: state_d = last_word ? StCsum : StData;
      StCsum:  if (accept) state_d = (rx_data == csum_q) ? StDone : StErr;
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode only the state register, so they never depend on rx_valid.
  always_comb begin
    rx_ready = 1'b0;
    mem_wren = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    error    = 1'b0;
    cpu_hold = 1'b1;
    unique case (state_q)
      StHdr, StLen, StData, StCsum: begin
        rx_ready = 1'b1;
        busy     = 1'b1;
      end
      StWrite: begin
        mem_wren = 1'b1;
        busy     = 1'b1;
      end
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StErr:   error = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge MAX10_CLK1_50 or posedge reset) begin
    if (reset) begin
      len_q        <= '0;
      word_idx_q   <= '0;
      byte_idx_q   <= '0;
      word_buf_q   <= '0;
      csum_q       <= '0;
      mem_addr_q   <= '0;
      mem_data_q   <= '0;
      word_count_q <= '0;
    end else begin
      if (arm) word_count_q <= '0;
      unique case (state_q)
        StLen: begin
          if (accept && len_ok) begin
            len_q      <= CW'(rx_data);
            word_idx_q <= '0;
            byte_idx_q <= '0;
            csum_q     <= '0;
          end
        end
        StData: begin
          if (accept) begin
            // Shift right so lane 0 (first byte) ends up least significant.
            word_buf_q <= {rx_data, word_buf_q[23:8]};
            csum_q     <= csum_q ^ rx_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            if (byte_idx_q == 2'd3) begin
              mem_data_q <= {rx_data, word_buf_q};
              mem_addr_q <= word_idx_q[ADDR_WIDTH-1:0];
            end
          end
        end
        StWrite: begin
          word_count_q <= word_count_q + CW'(1);
          if (!last_word) word_idx_q <= word_idx_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign mem_address = mem_addr_q;
  assign mem_data    = mem_data_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Scoreboarded bench for instr_mem_loader: expected writes are queued by the stimulus and
// retired by an independent write monitor; status is checked after each frame.
module tb_instr_mem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [4:0]  mem_address;
  logic [31:0] mem_data;
  logic        mem_wren;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;
  logic [5:0]  word_count;

  instr_mem_loader #(
    .ADDR_WIDTH (5),
    .MAX_WORDS  (32),
    .HEADER_BYTE(8'hA5)
  ) dut (
    .MAX10_CLK1_50(clk),
    .reset        (reset),
    .start        (start),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .mem_address  (mem_address),
    .mem_data     (mem_data),
    .mem_wren     (mem_wren),
    .cpu_hold     (cpu_hold),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .word_count   (word_count)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  pass_cnt = 0;
  int  total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Write monitor: every mem_wren cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (mem_wren === 1'b1) begin
      wr_t e;
      check("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                 mem_address, mem_data);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {27'd0, mem_address}, {27'd0, e.addr});
        check("write_data", mem_data, e.data);
      end
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n;
    if (gaps && $urandom_range(0, 2) == 0) begin
      rx_valid = 1'b0;
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    n = 0;
    while (rx_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rx_ready !== 1'b1) begin
      total_cnt++;
      $display("FAIL byte_timeout: got rx_ready %b expected 1 within 20 cycles", rx_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [31:0] words[$], input logic [7:0] csum, input bit gaps);
    pulse_start();
    check("busy_after_start", {31'd0, busy}, 32'd1);
    foreach (words[i]) exp_q.push_back('{addr: 5'(i), data: words[i]});
    send_byte(8'hA5, gaps);
    send_byte(8'(words.size()), gaps);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) send_byte(words[i][8*k +: 8], gaps);
    end
    send_byte(csum, gaps);
    rx_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_status(input string tag, input bit d, input bit e, input bit h,
                              input logic [5:0] wc);
    check({tag, "_done"}, {31'd0, done}, {31'd0, d});
    check({tag, "_error"}, {31'd0, error}, {31'd0, e});
    check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_word_count"}, {26'd0, word_count}, {26'd0, wc});
    check({tag, "_queue_empty"}, exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [31:0] basic[$];
    logic [31:0] big[$];
    logic [7:0]  big_csum;

    basic = '{32'h11223344, 32'hDEADBEEF};
    reset = 1'b1;
    start = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    check("rst_mem_address", {27'd0, mem_address}, 32'd0);
    check("rst_mem_data", mem_data, 32'd0);
    check_status("rst", 1'b0, 1'b0, 1'b1, 6'd0);
    reset = 1'b0;
    @(negedge clk);

    // Basic load; checksum 66 is the XOR of the eight data bytes.
    send_frame(basic, 8'h66, 1'b0);
    check_status("basic", 1'b1, 1'b0, 1'b0, 6'd2);

    // Bad header, then recovery.
    pulse_start();
    check("rearm_clears_done", {31'd0, done}, 32'd0);
    send_byte(8'h5A, 1'b0);
    rx_valid = 1'b0;
    @(negedge clk);
    check_status("bad_hdr", 1'b0, 1'b1, 1'b1, 6'd0);
    send_frame(basic, 8'h66, 1'b0);
    check_status("hdr_recover", 1'b1, 1'b0, 1'b0, 6'd2);

    // Length limits.
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    rx_valid = 1'b0;
    @(negedge clk);
    check_status("len_zero", 1'b0, 1'b1, 1'b1, 6'd0);
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'd33, 1'b0);
    rx_valid = 1'b0;
    @(negedge clk);
    check_status("len_33", 1'b0, 1'b1, 1'b1, 6'd0);

    big_csum = 8'h00;
    for (int i = 0; i < 32; i++) begin
      big.push_back({8'(i * 7 + 1), 8'(i ^ 8'h5A), 8'(8'hFF - i), 8'(i * 3)});
      for (int k = 0; k < 4; k++) big_csum ^= big[i][8*k +: 8];
    end
    send_frame(big, big_csum, 1'b0);
    check("max_last_addr", {27'd0, mem_address}, 32'd31);
    check_status("len_max", 1'b1, 1'b0, 1'b0, 6'd32);

    // Bad checksum: words still land in memory.
    send_frame(basic, 8'h67, 1'b0);
    check_status("bad_csum", 1'b0, 1'b1, 1'b1, 6'd2);

    // Flow control with random gaps; valid held high across WRITE.
    send_frame(basic, 8'h66, 1'b1);
    check_status("gaps", 1'b1, 1'b0, 1'b0, 6'd2);

    // Reset after the fifth data byte.
    exp_q.push_back('{addr: 5'd0, data: 32'h11223344});
    pulse_start();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'hEF, 1'b0);
    rx_valid = 1'b0;
    check("pre_reset_busy", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_mem_wren", {31'd0, mem_wren}, 32'd0);
    check_status("mid_rst", 1'b0, 1'b0, 1'b1, 6'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_frame(basic, 8'h66, 1'b0);
    check_status("post_rst", 1'b1, 1'b0, 1'b0, 6'd2);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
